// File: rtl/eth_rx_stream_arbiter.sv
// Round-robin, frame-locked merge of N_PORTS AXI-Stream sources onto one registered output.
// Define ETH_RX_ARB_STAT_EN to add per-port 16-bit completed-frame counters on frame_cnt.
module eth_rx_stream_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_PORTS-1:0]              s_axis_tvalid,
  input  logic [N_PORTS-1:0]              s_axis_tlast,
  output logic [N_PORTS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [$clog2(N_PORTS)-1:0]      grant_id,
  output logic                            busy
`ifdef ETH_RX_ARB_STAT_EN
  ,
  output logic [N_PORTS*16-1:0]           frame_cnt
`endif
);

  localparam int GW = $clog2(N_PORTS);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                  state_reg, state_next;
  logic [GW-1:0]           grant_reg, grant_next;
  logic [GW-1:0]           last_grant_reg, last_grant_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic [GW-1:0]           pick_idx, cand_idx;
  logic                    pick_valid;
  logic                    out_ready, accept;
  int                      cand;
  logic [DATA_WIDTH-1:0]   port_data [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_slice
      assign port_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the port right after last_grant wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = int'(last_grant_reg) + k;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      cand_idx = GW'(cand);
      if (s_axis_tvalid[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    data_next       = data_reg;
    valid_next      = valid_reg;
    last_next       = last_reg;
    s_axis_tready   = '0;
    out_ready       = !valid_reg || m_axis_tready;
    accept          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_idx;
          state_next = XFER;
        end
      end
      XFER: begin
        s_axis_tready[grant_reg] = out_ready;
        accept = s_axis_tvalid[grant_reg] && out_ready;
        if (accept && s_axis_tlast[grant_reg]) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Output register keeps draining in IDLE; it only loads from an accepted beat.
    if (accept) begin
      data_next  = port_data[grant_reg];
      last_next  = s_axis_tlast[grant_reg];
      valid_next = 1'b1;
    end else if (m_axis_tready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(N_PORTS - 1);
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      last_reg       <= last_next;
    end
  end

  assign m_axis_tdata  = data_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tlast  = last_reg;
  assign grant_id      = grant_reg;
  assign busy          = (state_reg == XFER);

`ifdef ETH_RX_ARB_STAT_EN
  logic [15:0] cnt_reg [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stat
      always_ff @(posedge aclk) begin
        if (areset) begin
          cnt_reg[gi] <= '0;
        end else if (accept && s_axis_tlast[grant_reg] && (grant_reg == GW'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
      assign frame_cnt[gi*16 +: 16] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule
